// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the five-stage integer core.
//
// Merges the decode (load-use), execute (multi-cycle) and memory (bus wait)
// stall requests into one per-stage hold vector. Times multi-cycle execute
// operations and drives the pipeline flush on exception or redirect. Also keeps
// a saturating count of cycles in which the PC was held.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst            in   asynchronous active-low reset
//   stallreq_id    in   load-use hazard from decode (level)
//   stallreq_mem   in   memory stage waiting on the bus (level)
//   mc_start       in   execute begins a multi-cycle op (pulse)
//   mc_len         in   op length in cycles, sampled with mc_start (0 means 1)
//   flush_req      in   exception or redirect (pulse)
//   perf_clr       in   synchronous clear of perf_stall_cnt
//   stall          out  hold bits [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
//   flush          out  clear all stage registers this cycle
//   mc_done        out  multi-cycle result valid
//   mc_abort       out  in-flight multi-cycle op cancelled by flush
//   busy           out  controller is not in RUN
//   perf_stall_cnt out  saturating count of cycles with stall[0] = 1
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_len,
    input  logic              flush_req,
    input  logic              perf_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              mc_done,
    output logic              mc_abort,
    output logic              busy,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  perf_q, perf_d;

    logic               start_ok;
    logic               ex_stall;
    logic [CNT_W-1:0]   len_eff;
    logic [5:0]         stall_raw;

    // A new op may be accepted in RUN, or in DONE once the result is being
    // handed over (back-to-back). A memory stall freezes execute, so the start
    // is dropped in that case.
    assign start_ok = mc_start && !stallreq_mem && (state_q != ST_BUSY);
    assign ex_stall = (state_q == ST_BUSY) || start_ok;
    assign len_eff  = (mc_len == '0) ? CNT_W'(1) : mc_len;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        stall_raw = STALL_NONE;
        if (flush_req) begin
            stall_raw = STALL_NONE;
        end else if (stallreq_mem) begin
            stall_raw = STALL_MEM;
        end else if (ex_stall) begin
            stall_raw = STALL_EX;
        end else if (stallreq_id) begin
            stall_raw = STALL_ID;
        end
    end

    // Next-state logic for the multi-cycle sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (start_ok) begin
                        cnt_d   = len_eff - CNT_W'(1);
                        state_d = (len_eff == CNT_W'(1)) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Keeps counting through memory stalls; the unit is still
                    // computing. Leaving at cnt <= 1 means cnt never wraps.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start_ok) begin
                        cnt_d   = len_eff - CNT_W'(1);
                        state_d = (len_eff == CNT_W'(1)) ? ST_DONE : ST_BUSY;
                    end else if (!stallreq_mem) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Saturating stall counter; clear has priority over counting.
    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (stall_raw[0] && !(&perf_q)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    // Outputs are held inactive for the whole time reset is asserted, not just
    // from the next edge, so the stage registers see a clean pipeline.
    assign stall          = rst ? stall_raw : STALL_NONE;
    assign flush          = rst && flush_req;
    assign mc_abort       = rst && flush_req && (state_q != ST_RUN);
    assign mc_done        = rst && !flush_req && (state_q == ST_DONE);
    assign busy           = rst && (state_q != ST_RUN);
    assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl.
//
// The stimulus process drives one cycle at a time and pushes the hand-derived
// expected outputs for that cycle into a queue. A monitor samples the DUT on
// the falling edge and pops/compares. A second instance with PERF_W = 4 is
// used to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        done;
        logic        abort;
        logic        busy;
        logic [31:0] perf;
        logic [5:0]  stall4;
        logic [3:0]  perf4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_mem, mc_start, flush_req, perf_clr;
    logic [5:0]  mc_len;
    logic [5:0]  stall;
    logic        flush, mc_done, mc_abort, busy;
    logic [31:0] perf_stall_cnt;

    logic        id4, clr4;
    logic [5:0]  stall4;
    logic        flush4, done4, abort4, busy4;
    logic [3:0]  perf4;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_perf = 0;
    logic [3:0]  exp_perf4 = 0;

    pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .mc_start(mc_start), .mc_len(mc_len),
        .flush_req(flush_req), .perf_clr(perf_clr),
        .stall(stall), .flush(flush), .mc_done(mc_done),
        .mc_abort(mc_abort), .busy(busy), .perf_stall_cnt(perf_stall_cnt)
    );

    pipe_ctrl #(.CNT_W(6), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .stallreq_id(id4), .stallreq_mem(1'b0),
        .mc_start(1'b0), .mc_len(6'd0),
        .flush_req(1'b0), .perf_clr(clr4),
        .stall(stall4), .flush(flush4), .mc_done(done4),
        .mc_abort(abort4), .busy(busy4), .perf_stall_cnt(perf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("stall",    32'(stall),    32'(e.stall));
                check("flush",    32'(flush),    32'(e.flush));
                check("mc_done",  32'(mc_done),  32'(e.done));
                check("mc_abort", 32'(mc_abort), 32'(e.abort));
                check("busy",     32'(busy),     32'(e.busy));
                check("perf",     perf_stall_cnt, e.perf);
                check("stall4",   32'(stall4),   32'(e.stall4));
                check("perf4",    32'(perf4),    32'(e.perf4));
                check("misc4",    32'({flush4, done4, abort4, busy4}), 32'd0);
            end
        end
    end

    task automatic drv(input logic id, input logic mem, input logic st,
                       input logic [5:0] len, input logic fl);
        stallreq_id  = id;
        stallreq_mem = mem;
        mc_start     = st;
        mc_len       = len;
        flush_req    = fl;
        perf_clr     = 1'b0;
    endtask

    // One clock cycle: queue the expected outputs for the current inputs,
    // then advance. The perf expectations follow from the expected stall bits.
    task automatic step(input logic [5:0] es, input logic ef, input logic ed,
                        input logic ea, input logic eb);
        exp_t e;
        logic [5:0] es4;
        es4 = (rst && id4) ? 6'b000111 : 6'b000000;
        e.stall  = es;
        e.flush  = ef;
        e.done   = ed;
        e.abort  = ea;
        e.busy   = eb;
        e.perf   = exp_perf;
        e.stall4 = es4;
        e.perf4  = exp_perf4;
        sb_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            exp_perf  = 0;
            exp_perf4 = 0;
        end else begin
            if (perf_clr) exp_perf = 0;
            else if (es[0] && exp_perf != 32'hFFFF_FFFF) exp_perf = exp_perf + 1;
            if (clr4) exp_perf4 = 0;
            else if (es4[0] && exp_perf4 != 4'hF) exp_perf4 = exp_perf4 + 1;
        end
        #1;
    endtask

    localparam logic [5:0] S0  = 6'b000000;
    localparam logic [5:0] SM  = 6'b011111;
    localparam logic [5:0] SX  = 6'b001111;
    localparam logic [5:0] SI  = 6'b000111;

    initial begin
        rst = 1'b0;
        id4 = 1'b0;
        clr4 = 1'b0;
        drv(1, 1, 1, 6'd5, 1);
        perf_clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with every request high: all outputs forced low.
        step(S0, 0, 0, 0, 0);
        step(S0, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0);
        step(S0, 0, 0, 0, 0);
        rst = 1'b1;
        step(S0, 0, 0, 0, 0);
        step(S0, 0, 0, 0, 0);

        // Multi-cycle op, length 4.
        drv(0, 0, 1, 6'd4, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0);
        for (int i = 1; i <= 3; i++) step(SX, 0, 0, 0, 1);
        step(S0, 0, 1, 0, 1);
        step(S0, 0, 0, 0, 0);

        // Length 0 is treated as 1.
        drv(0, 0, 1, 6'd0, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0); step(S0, 0, 1, 0, 1);
        step(S0, 0, 0, 0, 0);

        // Memory stall overlapping a length-4 op in cycles 2-6. DONE is held
        // until the first cycle without a memory stall (cycle 7).
        drv(0, 0, 1, 6'd4, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0); step(SX, 0, 0, 0, 1);
        drv(0, 1, 0, 6'd0, 0);
        step(SM, 0, 0, 0, 1);
        step(SM, 0, 0, 0, 1);
        for (int i = 4; i <= 6; i++) step(SM, 0, 1, 0, 1);
        drv(0, 0, 0, 6'd0, 0);
        step(S0, 0, 1, 0, 1);
        step(S0, 0, 0, 0, 0);

        // Load-use for two cycles after a counter clear.
        perf_clr = 1'b1; step(S0, 0, 0, 0, 0);
        drv(1, 0, 0, 6'd0, 0);
        step(SI, 0, 0, 0, 0);
        step(SI, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0);
        step(S0, 0, 0, 0, 0);
        check("perf_after_load_use", perf_stall_cnt, 32'd2);

        // Flush in cycle 3 of a length-10 op.
        drv(0, 0, 1, 6'd10, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0);
        step(SX, 0, 0, 0, 1);
        step(SX, 0, 0, 0, 1);
        drv(1, 1, 0, 6'd0, 1); step(S0, 1, 0, 1, 1);
        drv(0, 0, 0, 6'd0, 0);
        for (int i = 0; i < 12; i++) step(S0, 0, 0, 0, 0);

        // Flush together with mc_start in RUN: no op starts, no abort.
        drv(0, 0, 1, 6'd3, 1); step(S0, 1, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0); step(S0, 0, 0, 0, 0);

        // Back-to-back: length 1, then length 2 started in the DONE cycle.
        drv(0, 0, 1, 6'd1, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 1, 6'd2, 0); step(SX, 0, 1, 0, 1);
        drv(0, 0, 0, 6'd0, 0); step(SX, 0, 0, 0, 1);
        step(S0, 0, 1, 0, 1);
        step(S0, 0, 0, 0, 0);

        // Load-use held across a length-3 op: covered by the execute stall,
        // then shows as 000111 once the op completes.
        drv(1, 0, 1, 6'd3, 0); step(SX, 0, 0, 0, 0);
        drv(1, 0, 0, 6'd0, 0);
        step(SX, 0, 0, 0, 1);
        step(SX, 0, 0, 0, 1);
        step(SI, 0, 1, 0, 1);
        drv(0, 0, 0, 6'd0, 0); step(S0, 0, 0, 0, 0);

        // mc_start during a memory stall in RUN is dropped.
        drv(0, 1, 1, 6'd3, 0); step(SM, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0); step(S0, 0, 0, 0, 0);

        // Maximum length 63.
        drv(0, 0, 1, 6'd63, 0); step(SX, 0, 0, 0, 0);
        drv(0, 0, 0, 6'd0, 0);
        for (int i = 1; i <= 62; i++) step(SX, 0, 0, 0, 1);
        step(S0, 0, 1, 0, 1);
        step(S0, 0, 0, 0, 0);

        // Saturation on the 4-bit instance: 20 stall cycles, then clear.
        id4 = 1'b1;
        for (int i = 0; i < 20; i++) step(S0, 0, 0, 0, 0);
        id4 = 1'b0;
        step(S0, 0, 0, 0, 0);
        check("perf4_saturated", 32'(perf4), 32'hF);
        clr4 = 1'b1; step(S0, 0, 0, 0, 0);
        clr4 = 1'b0;
        check("perf4_cleared", 32'(perf4), 32'h0);
        step(S0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
